mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit feeding the Hi and Lo registers of the multicycle CPU.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands, retiring BITS_PER_CYCLE result bits per clock.
- The control FSM raises start, holds in a wait state while busy, and asserts HiLo_load on the done pulse.
- Successor to the fixed single-purpose Hi/Lo datapath: width, throughput, signed/unsigned modes and divide-by-zero signalling are all generalised.

---
 rtl/mult_div_if.sv | 34 +++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// Ports (slave view):
//   start    in   operation request, sampled only while idle
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_in     in   multiplicand / dividend
//   b_in     in   multiplier / divisor
//   busy     out  high while an operation is in flight or completing
//   done     out  single-cycle completion pulse
//   div_zero out  divide-by-zero flag, meaningful only with done
//   hi_out   out  product upper half / remainder
//   lo_out   out  product lower half / quotient
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide unit producing Hi/Lo results.
// Operands are converted to magnitudes at the start edge, BITS_PER_CYCLE
// shift-add (multiply) or restoring shift-subtract (divide) steps run per
// clock, and the sign is re-applied on the final iteration.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   bus    mult_div_if.slave  request/result bundle (see mult_div_if.sv)
module mult_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_ITER = CW'(ITER);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_pq_q, neg_pq_d;   // product / quotient negative
    logic             neg_r_q, neg_r_d;     // remainder negative
    logic [WIDTH-1:0] wl_q, wl_d;           // multiplier bits / dividend-quotient shifter
    logic [WIDTH-1:0] wh_q, wh_d;           // partial product high half / partial remainder
    logic [WIDTH-1:0] wb_q, wb_d;           // multiplicand / divisor magnitude
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               sa_s, sb_s;
    logic [WIDTH:0]     ext_s;
    logic [WIDTH-1:0]   step_h_s, step_l_s;
    logic [2*WIDTH-1:0] prod_s;

    // Next-state, datapath iteration and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_pq_d = neg_pq_q;
        neg_r_d  = neg_r_q;
        wl_d     = wl_q;
        wh_d     = wh_q;
        wb_d     = wb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sa_s     = 1'b0;
        sb_s     = 1'b0;
        ext_s    = {(WIDTH+1){1'b0}};
        step_h_s = wh_q;
        step_l_s = wl_q;
        prod_s   = {2*WIDTH{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // op[0]=0 selects the signed variants.
                    sa_s     = ~bus.op[0] & bus.a_in[WIDTH-1];
                    sb_s     = ~bus.op[0] & bus.b_in[WIDTH-1];
                    wl_d     = sa_s ? -bus.a_in : bus.a_in;
                    wb_d     = sb_s ? -bus.b_in : bus.b_in;
                    wh_d     = {WIDTH{1'b0}};
                    is_div_d = bus.op[1];
                    neg_pq_d = sa_s ^ sb_s;
                    neg_r_d  = sa_s;
                    cnt_d    = CNT_ITER;
                    busy_d   = 1'b1;
                    if (bus.op[1] && (bus.b_in == {WIDTH{1'b0}})) begin
                        // Divide by zero: report immediately, keep old results.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int k = 0; k < BITS_PER_CYCLE; k++) begin
                    if (is_div_q) begin
                        ext_s    = {step_h_s, step_l_s[WIDTH-1]};
                        step_l_s = {step_l_s[WIDTH-2:0], 1'b0};
                        if (ext_s >= {1'b0, wb_q}) begin
                            ext_s       = ext_s - {1'b0, wb_q};
                            step_l_s[0] = 1'b1;
                        end else begin
                            ext_s = ext_s;
                        end
                        step_h_s = ext_s[WIDTH-1:0];
                    end else begin
                        // Right-shifting accumulator; the carry becomes the new MSB.
                        ext_s    = {1'b0, step_h_s} +
                                   (step_l_s[0] ? {1'b0, wb_q} : {(WIDTH+1){1'b0}});
                        step_l_s = {ext_s[0], step_l_s[WIDTH-1:1]};
                        step_h_s = ext_s[WIDTH:1];
                    end
                end
                wh_d  = step_h_s;
                wl_d  = step_l_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (is_div_q) begin
                        lo_d = neg_pq_q ? -step_l_s : step_l_s;
                        hi_d = neg_r_q  ? -step_h_s : step_h_s;
                    end else begin
                        prod_s = {step_h_s, step_l_s};
                        prod_s = neg_pq_q ? -prod_s : prod_s;
                        hi_d   = prod_s[2*WIDTH-1:WIDTH];
                        lo_d   = prod_s[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
            wl_q     <= {WIDTH{1'b0}};
            wh_q     <= {WIDTH{1'b0}};
            wb_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_pq_q <= neg_pq_d;
            neg_r_q  <= neg_r_d;
            wl_q     <= wl_d;
            wh_q     <= wh_d;
            wb_q     <= wb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(W)) bus1();
    mult_div_if #(.WIDTH(W)) bus4();

    mult_div_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    mult_div_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_hi [2];
    logic [W-1:0] exp_lo [2];

    // Output view selected by unit index: 0 = one bit/cycle, 1 = four bits/cycle.
    function automatic logic get_busy(input int u);
        return (u == 0) ? bus1.busy : bus4.busy;
    endfunction
    function automatic logic get_done(input int u);
        return (u == 0) ? bus1.done : bus4.done;
    endfunction
    function automatic logic get_dz(input int u);
        return (u == 0) ? bus1.div_zero : bus4.div_zero;
    endfunction
    function automatic logic [W-1:0] get_hi(input int u);
        return (u == 0) ? bus1.hi_out : bus4.hi_out;
    endfunction
    function automatic logic [W-1:0] get_lo(input int u);
        return (u == 0) ? bus1.lo_out : bus4.lo_out;
    endfunction

    task automatic set_in(input int u, input logic s, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        if (u == 0) begin
            bus1.start = s; bus1.op = op; bus1.a_in = a; bus1.b_in = b;
        end else begin
            bus4.start = s; bus4.op = op; bus4.a_in = a; bus4.b_in = b;
        end
    endtask

    // Arithmetic reference: 64-bit integer math, truncating division.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] ph,
                                  input logic [W-1:0] pl, output logic [W-1:0] h,
                                  output logic [W-1:0] l, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] up;
        dz = 1'b0; h = ph; l = pl;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin q = sa * sb; up = q; h = up[63:32]; l = up[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
            2'b10: begin
                if (b == 32'd0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; up = q; l = up[31:0]; up = r; h = up[31:0]; end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // Issue one operation and observe the whole busy window.
    task automatic run_op(input int u, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke, input string name);
        logic [W-1:0] eh, el, gh, gl;
        logic edz, gz;
        int iter, exp_at, done_cnt, done_at, busy_cnt, zbad;
        iter = (u == 0) ? 32 : 8;
        model(op, a, b, exp_hi[u], exp_lo[u], eh, el, edz);
        exp_at = edz ? 0 : iter;
        done_cnt = 0; done_at = -1; busy_cnt = 0; zbad = 0;
        gh = '0; gl = '0; gz = 1'b0;
        set_in(u, 1'b1, op, a, b);
        @(posedge clk); #1;
        set_in(u, 1'b0, 2'($urandom), $urandom, $urandom);
        for (int j = 0; j <= iter + 2; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (poke && j == 5) set_in(u, 1'b1, 2'($urandom), $urandom, $urandom);
            if (poke && j == 6) set_in(u, 1'b0, 2'($urandom), $urandom, $urandom);
            if (get_busy(u)) busy_cnt++;
            if (!get_done(u) && get_dz(u)) zbad++;
            if (get_done(u)) begin
                done_cnt++; done_at = j;
                gh = get_hi(u); gl = get_lo(u); gz = get_dz(u);
            end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt); end
        checks++; if (done_at !== exp_at) begin failures++; $display("FAIL %s done_latency got=%0d exp=%0d", name, done_at, exp_at); end
        checks++; if (busy_cnt !== exp_at + 1) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_at + 1); end
        checks++; if (gh !== eh) begin failures++; $display("FAIL %s hi got=%h exp=%h", name, gh, eh); end
        checks++; if (gl !== el) begin failures++; $display("FAIL %s lo got=%h exp=%h", name, gl, el); end
        checks++; if (gz !== edz) begin failures++; $display("FAIL %s div_zero got=%b exp=%b", name, gz, edz); end
        checks++; if (zbad !== 0) begin failures++; $display("FAIL %s div_zero_without_done got=%0d exp=0", name, zbad); end
        exp_hi[u] = eh;
        exp_lo[u] = el;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(0, 1'b0, 2'b00, '0, '0);
        set_in(1, 1'b0, 2'b00, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++; if ({get_busy(u), get_done(u), get_dz(u)} !== 3'b000) begin failures++; $display("FAIL reset_flags u%0d got=%b exp=000", u, {get_busy(u), get_done(u), get_dz(u)}); end
            checks++; if ({get_hi(u), get_lo(u)} !== 64'd0) begin failures++; $display("FAIL reset_hilo u%0d got=%h exp=0", u, {get_hi(u), get_lo(u)}); end
            exp_hi[u] = '0; exp_lo[u] = '0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op(0, 2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, "mult_neg");
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'hFFFFFFFF_FFFFFFEB) begin failures++; $display("FAIL mult_neg_const got=%h exp=ffffffffffffffeb", {bus1.hi_out, bus1.lo_out}); end
        run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'hFFFFFFFE_00000001) begin failures++; $display("FAIL multu_max_const got=%h exp=fffffffe00000001", {bus1.hi_out, bus1.lo_out}); end
    endtask

    task automatic test_div();
        run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "div_neg");
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_neg_const got=%h exp=fffffffffffffffd", {bus1.hi_out, bus1.lo_out}); end
        run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_min_m1");
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'h00000000_80000000) begin failures++; $display("FAIL div_min_m1_const got=%h exp=0000000080000000", {bus1.hi_out, bus1.lo_out}); end
    endtask

    task automatic test_div_zero();
        run_op(0, 2'b11, 32'd7, 32'd2, 1'b0, "divu_7_2");
        run_op(0, 2'b11, 32'd5, 32'd0, 1'b0, "divu_zero");
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'h00000001_00000003) begin failures++; $display("FAIL divu_zero_hold got=%h exp=0000000100000003", {bus1.hi_out, bus1.lo_out}); end
        run_op(0, 2'b10, 32'hFFFFFFF0, 32'd0, 1'b0, "div_zero_signed");
    endtask

    task automatic test_bpc4();
        run_op(1, 2'b01, 32'h1234, 32'h10, 1'b0, "bpc4_multu");
        checks++; if (bus4.lo_out !== 32'h00012340) begin failures++; $display("FAIL bpc4_multu_const got=%h exp=00012340", bus4.lo_out); end
        run_op(1, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, "bpc4_div");
    endtask

    task automatic test_start_mid_run();
        run_op(0, 2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1, "poke_mult");
        run_op(1, 2'b11, 32'hDEADBEEF, 32'h00001234, 1'b1, "poke_divu4");
    endtask

    task automatic test_reset_mid_run();
        int dcnt;
        dcnt = 0;
        set_in(0, 1'b1, 2'b01, 32'h0000FFFF, 32'h00010001);
        @(posedge clk); #1;
        set_in(0, 1'b0, 2'b00, '0, '0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL midrun_reset_busy got=%b exp=0", bus1.busy); end
        checks++; if ({bus1.hi_out, bus1.lo_out} !== 64'd0) begin failures++; $display("FAIL midrun_reset_hilo got=%h exp=0", {bus1.hi_out, bus1.lo_out}); end
        checks++; if ({bus4.hi_out, bus4.lo_out} !== 64'd0) begin failures++; $display("FAIL midrun_reset_hilo4 got=%h exp=0", {bus4.hi_out, bus4.lo_out}); end
        @(negedge clk);
        reset = 1'b1;
        exp_hi[0] = '0; exp_lo[0] = '0; exp_hi[1] = '0; exp_lo[1] = '0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (bus1.done || bus1.busy) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL midrun_reset_no_done got=%0d exp=0", dcnt); end
        run_op(0, 2'b00, 32'h00000003, 32'hFFFFFFFE, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = $urandom_range(1, 9);
                default: ;
            endcase
            run_op((i % 3 == 2) ? 1 : 0, 2'($urandom), a, b, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(1, 2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, "b2b_0");
        run_op(1, 2'b10, 32'h00000064, 32'hFFFFFFF9, 1'b0, "b2b_1");
        run_op(1, 2'b11, 32'h00000000, 32'h00000003, 1'b0, "b2b_2");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_bpc4();
        test_start_mid_run();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
